// File: rtl/can_bit_sync.sv
// can_bit_sync: CAN receive bit timing with hard sync at SOF and SJW-limited resync on recessive->dominant edges.
// Optional macro TRIPLE_SAMPLE_EN: rx_bit becomes the majority of three samples ending at the sample point.
module can_bit_sync #(
   parameter int CLOCK_FREQ = 100_000_000,
   parameter int BAUD_RATE  = 500_000,
   parameter int TSEG1      = 6,
   parameter int TSEG2      = 3,
   parameter int SJW        = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic rx,
   input  logic hard_sync_en,
   output logic rx_sync,
   output logic sample_point,
   output logic rx_bit,
   output logic tx_point
);
   localparam int BRP   = CLOCK_FREQ / (BAUD_RATE * (1 + TSEG1 + TSEG2));
   localparam int PW    = (BRP > 1) ? $clog2(BRP) : 1;
   localparam int TQMAX = (TSEG1 + SJW > TSEG2) ? TSEG1 + SJW : TSEG2;
   localparam int TW    = $clog2(TQMAX + 1);
   localparam int SW    = $clog2(SJW + 1);

   typedef enum logic [1:0] {ST_SYNC = 2'd0, ST_TSEG1 = 2'd1, ST_TSEG2 = 2'd2} state_t;

   logic          sync1_q, sync2_q;
   logic [PW-1:0] presc_q, presc_d;
   state_t        state_q, state_d;
   logic [TW-1:0] tq_q, tq_d;
   logic [SW-1:0] ext_q, ext_d, short_q, short_d;
   logic          resync_done_q, resync_done_d;
   logic          rx_bit_q, rx_bit_d;
   logic          sample_q, sample_d;
   logic          tx_q, tx_d;
   logic          start_q;
   logic          tick_s, edge_s, sample_val_s;

`ifdef TRIPLE_SAMPLE_EN
   logic samp1_q, samp1_d, samp2_q, samp2_d;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   assign sample_val_s = maj3(samp1_q, samp2_q, sync2_q);
`else
   assign sample_val_s = sync2_q;
`endif

   assign tick_s = (presc_q == PW'(BRP - 1));
   // Edge is seen one stage early so the edge cycle itself can be presc=0 / carry tx_point.
   assign edge_s = sync2_q & ~sync1_q;

   always_comb begin
      presc_d       = tick_s ? '0 : presc_q + PW'(1);
      state_d       = state_q;
      tq_d          = tq_q;
      ext_d         = ext_q;
      short_d       = short_q;
      resync_done_d = resync_done_q;
      rx_bit_d      = rx_bit_q;
      sample_d      = 1'b0;
      tx_d          = 1'b0;
`ifdef TRIPLE_SAMPLE_EN
      samp1_d       = samp1_q;
      samp2_d       = samp2_q;
`endif
      if (start_q) begin
         presc_d = '0;
         state_d = ST_SYNC;
         tq_d    = '0;
         tx_d    = 1'b1;
      end else if (tick_s) begin
         case (state_q)
            ST_SYNC: begin
               state_d = ST_TSEG1;
               tq_d    = '0;
            end
            ST_TSEG1: begin
`ifdef TRIPLE_SAMPLE_EN
               if (tq_q == TW'(TSEG1 - 3) + TW'(ext_q)) begin
                  samp1_d = sync2_q;
               end else if (tq_q == TW'(TSEG1 - 2) + TW'(ext_q)) begin
                  samp2_d = sync2_q;
               end else begin
                  samp1_d = samp1_q;
               end
`endif
               if (tq_q >= TW'(TSEG1 - 1) + TW'(ext_q)) begin
                  state_d       = ST_TSEG2;
                  tq_d          = '0;
                  sample_d      = 1'b1;
                  rx_bit_d      = sample_val_s;
                  resync_done_d = 1'b0;
               end else begin
                  tq_d = tq_q + TW'(1);
               end
            end
            ST_TSEG2: begin
               if (tq_q + TW'(short_q) >= TW'(TSEG2 - 1)) begin
                  state_d = ST_SYNC;
                  tq_d    = '0;
                  ext_d   = '0;
                  short_d = '0;
                  tx_d    = 1'b1;
               end else begin
                  tq_d = tq_q + TW'(1);
               end
            end
            default: begin
               state_d = ST_SYNC;
               tq_d    = '0;
            end
         endcase
      end else begin
         state_d = state_q;
      end

      // The nominal next values describe the edge cycle; edge effects are applied on top.
      if (edge_s && hard_sync_en) begin
         presc_d       = '0;
         state_d       = ST_SYNC;
         tq_d          = '0;
         ext_d         = '0;
         short_d       = '0;
         tx_d          = 1'b0;
         resync_done_d = 1'b1;
      end else if (edge_s && rx_bit_d && !resync_done_d) begin
         resync_done_d = 1'b1;
         case (state_d)
            ST_TSEG1: ext_d = (tq_d >= TW'(SJW - 1)) ? SW'(SJW) : SW'(tq_d + TW'(1));
            ST_TSEG2: begin
               if (TW'(TSEG2) - tq_d <= TW'(SJW)) begin
                  presc_d = '0;
                  state_d = ST_SYNC;
                  tq_d    = '0;
                  ext_d   = '0;
                  short_d = '0;
                  tx_d    = ~sample_d;
               end else begin
                  short_d = SW'(SJW);
               end
            end
            default: ext_d = ext_q;
         endcase
      end else begin
         resync_done_d = resync_done_d;
      end
   end

   // Synchronizer, bit-timing state and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q       <= 1'b1;
         sync2_q       <= 1'b1;
         presc_q       <= '0;
         state_q       <= ST_SYNC;
         tq_q          <= '0;
         ext_q         <= '0;
         short_q       <= '0;
         resync_done_q <= 1'b0;
         rx_bit_q      <= 1'b1;
         sample_q      <= 1'b0;
         tx_q          <= 1'b0;
         start_q       <= 1'b1;
`ifdef TRIPLE_SAMPLE_EN
         samp1_q       <= 1'b1;
         samp2_q       <= 1'b1;
`endif
      end else begin
         sync1_q       <= rx;
         sync2_q       <= sync1_q;
         presc_q       <= presc_d;
         state_q       <= state_d;
         tq_q          <= tq_d;
         ext_q         <= ext_d;
         short_q       <= short_d;
         resync_done_q <= resync_done_d;
         rx_bit_q      <= rx_bit_d;
         sample_q      <= sample_d;
         tx_q          <= tx_d;
         start_q       <= 1'b0;
`ifdef TRIPLE_SAMPLE_EN
         samp1_q       <= samp1_d;
         samp2_q       <= samp2_d;
`endif
      end
   end

   assign rx_sync      = sync2_q;
   assign sample_point = sample_q;
   assign rx_bit       = rx_bit_q;
   assign tx_point     = tx_q;
endmodule

// File: tb/tb_can_bit_sync.sv
// tb_can_bit_sync: scoreboard bench; expected tx_point/sample_point pulses (cycle, rx_bit) are queued
// as stimulus is driven and popped when the DUT pulses.
module tb_can_bit_sync;
   logic clk = 1'b0, reset = 1'b1, rx = 1'b1, hard_sync_en = 1'b0;
   logic rx_sync, sample_point, rx_bit, tx_point;
   int   cyc = 0, total = 0, bad = 0;

   typedef struct {
      bit is_tx;
      int at;
      bit b;
   } ev_t;
   ev_t exp_q[$];

`ifdef TRIPLE_SAMPLE_EN
   localparam bit GLITCH_BIT = 1'b1;
`else
   localparam bit GLITCH_BIT = 1'b0;
`endif

   can_bit_sync dut (
      .clk(clk), .reset(reset), .rx(rx), .hard_sync_en(hard_sync_en),
      .rx_sync(rx_sync), .sample_point(sample_point), .rx_bit(rx_bit), .tx_point(tx_point)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input int obs, input int expv);
      total++;
      if (obs !== expv) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, expv, cyc);
      end
   endtask

   function automatic void push(input bit is_tx, input int at, input bit b);
      ev_t e;
      e.is_tx = is_tx;
      e.at    = at;
      e.b     = b;
      exp_q.push_back(e);
   endfunction

   task automatic wait_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // rx passes a 2-FF synchronizer: drive two cycles ahead so rx_sync changes in cycle t.
   task automatic rx_at(input int t, input logic v);
      wait_cyc(t - 2);
      rx = v;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_sp"}, int'(sample_point), 0);
      chk({tag, "_tp"}, int'(tx_point), 0);
      chk({tag, "_rxbit"}, int'(rx_bit), 1);
      chk({tag, "_rxsync"}, int'(rx_sync), 1);
   endtask

   always @(negedge clk) begin : monitor
      ev_t e;
      if (sample_point || tx_point) begin
         chk("sp_tp_excl", int'(sample_point & tx_point), 0);
         if (exp_q.size() == 0) begin
            chk("spurious_pulse", int'({sample_point, tx_point}), 0);
         end else begin
            e = exp_q.pop_front();
            chk(e.is_tx ? "kind_tx" : "kind_sp", int'(tx_point), int'(e.is_tx));
            chk(e.is_tx ? "when_tx" : "when_sp", cyc, e.at);
            if (!e.is_tx) chk("rx_bit", int'(rx_bit), int'(e.b));
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int b, e;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_vals("reset");
      reset = 1'b0;
      b = cyc + 1;

      // idle recessive bus: free-running 200-clk bits
      push(1'b1, b, 1'b0);
      push(1'b0, b + 140, 1'b1);
      push(1'b1, b + 200, 1'b0);
      push(1'b0, b + 340, 1'b1);
      push(1'b1, b + 400, 1'b0);
      b = b + 400;

      // late edge in TSEG1 k=0: ext=1
      rx_at(b + 30, 1'b0);
      push(1'b0, b + 160, 1'b0);
      push(1'b1, b + 220, 1'b0);
      rx_at(b + 170, 1'b1);
      b = b + 220;
      push(1'b0, b + 140, 1'b1);
      push(1'b1, b + 200, 1'b0);
      b = b + 200;

      // early edge in TSEG2 k=1 (rem<=SJW): restart with tx_point in edge cycle
      push(1'b0, b + 140, 1'b1);
      rx_at(b + 170, 1'b0);
      push(1'b1, b + 170, 1'b0);
      b = b + 170;
      // second edge in the same bit after a resync is ignored
      rx_at(b + 60, 1'b1);
      rx_at(b + 70, 1'b0);
      rx_at(b + 80, 1'b1);
      push(1'b0, b + 140, 1'b1);
      push(1'b1, b + 200, 1'b0);
      b = b + 200;

      // early edge in TSEG2 k=0 (rem>SJW): TSEG2 shortened by SJW
      push(1'b0, b + 140, 1'b1);
      rx_at(b + 145, 1'b0);
      push(1'b1, b + 160, 1'b0);
      b = b + 160;
      rx_at(b + 50, 1'b1);
      push(1'b0, b + 140, 1'b1);
      push(1'b1, b + 200, 1'b0);
      b = b + 200;

      // hard sync mid-TSEG1: edge cycle becomes bit start, no tx_point
      wait_cyc(b + 10);
      hard_sync_en = 1'b1;
      e = b + 60;
      rx_at(e, 1'b0);
      push(1'b0, e + 140, 1'b0);
      wait_cyc(e + 10);
      hard_sync_en = 1'b0;
      rx_at(e + 190, 1'b1);
      push(1'b1, e + 200, 1'b0);
      b = e + 200;

      // dominant glitch around the sample point while rx_bit=0: edge ignored
      rx_at(b + 130, 1'b0);
      push(1'b0, b + 140, GLITCH_BIT);
      rx_at(b + 150, 1'b1);
      push(1'b1, b + 200, 1'b0);
      b = b + 200;

      // reset mid-bit
      wait_cyc(b + 69);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_vals("midreset");
      chk("queue_at_reset", exp_q.size(), 0);
      reset = 1'b0;
      b = cyc + 1;
      push(1'b1, b, 1'b0);
      push(1'b0, b + 140, 1'b1);
      push(1'b1, b + 200, 1'b0);
      wait_cyc(b + 210);
      chk("queue_at_end", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
